// File: rtl/counter_load_sequencer.sv
// counter_load_sequencer: 8254 control-word decode and per-counter load sequencing.
// Define COUNTER_LATCH_CMD_EN to add the LATCH output pulsed by RW=00 latch commands.
module counter_load_sequencer #(
  parameter int LOAD_HOLD = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR,
  input  logic [1:0]  ADDR,
  input  logic [7:0]  DATA_IN,
  output logic [2:0]  COUNTER_SELECTOR,
  output logic [2:0]  NEW_COUNT,
  output logic [2:0]  TWO_BYTE_COUNTER,
  output logic [23:0] INITIAL_COUNT,
  output logic [8:0]  MODE,
  output logic [2:0]  BCD,
  output logic [5:0]  CNT_RW
`ifdef COUNTER_LATCH_CMD_EN
  ,
  output logic [2:0]  LATCH
`endif
);
  localparam int HW = $clog2(LOAD_HOLD + 1);
  typedef enum logic [2:0] {UNPROG, SELPULSE, WAIT_FIRST, WAIT_SECOND, HOLD, RUN} state_e;
  state_e        state_q [3];
  state_e        state_d [3];
  logic [HW-1:0] hold_q [3];
  logic [HW-1:0] hold_d [3];
  logic [2:0]    sel_q, sel_d, nc_q, nc_d, bcd_q, bcd_d;
  logic [23:0]   init_q, init_d;
  logic [8:0]    mode_q, mode_d;
  logic [5:0]    rw_q, rw_d;
  logic          cw_wr;
  logic [2:0]    m_in;
  assign cw_wr = WR && ADDR == 2'd3 && DATA_IN[7:6] != 2'd3 && DATA_IN[5:4] != 2'd0;
  // Modes 6/7 alias onto 2/3
  assign m_in = (DATA_IN[3] && DATA_IN[2]) ? {1'b0, DATA_IN[2:1]} : DATA_IN[3:1];
  always_comb begin
    sel_d  = sel_q;
    nc_d   = nc_q;
    bcd_d  = bcd_q;
    init_d = init_q;
    mode_d = mode_q;
    rw_d   = rw_q;
    for (int n = 0; n < 3; n++) begin
      state_d[n] = state_q[n];
      hold_d[n]  = hold_q[n];
      if (cw_wr && DATA_IN[7:6] == 2'(n)) begin
        mode_d[3*n +: 3] = m_in;
        bcd_d[n]         = DATA_IN[0];
        rw_d[2*n +: 2]   = DATA_IN[5:4];
        sel_d[n]         = 1'b0;
        nc_d[n]          = 1'b0;
        state_d[n]       = SELPULSE;
      end else begin
        if (state_q[n] == SELPULSE) begin
          sel_d[n]   = 1'b1;
          state_d[n] = WAIT_FIRST;
        end
        // The byte after an LSB in two-byte mode is the MSB; everything else restarts the load
        if (WR && ADDR == 2'(n) && state_q[n] != UNPROG) begin
          init_d[8*n +: 8] = DATA_IN;
          nc_d[n]          = 1'b0;
          state_d[n]       = (state_q[n] == WAIT_SECOND || rw_q[2*n +: 2] != 2'b11) ? HOLD : WAIT_SECOND;
          hold_d[n]        = HW'(LOAD_HOLD);
        end else if (state_q[n] == HOLD) begin
          hold_d[n] = hold_q[n] - HW'(1);
          if (hold_q[n] == HW'(1)) begin
            nc_d[n]    = 1'b1;
            state_d[n] = RUN;
          end
        end
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel_q  <= '0;
      nc_q   <= '1;
      bcd_q  <= '0;
      init_q <= '0;
      mode_q <= '0;
      rw_q   <= '0;
      for (int n = 0; n < 3; n++) begin
        state_q[n] <= UNPROG;
        hold_q[n]  <= '0;
      end
    end else begin
      sel_q  <= sel_d;
      nc_q   <= nc_d;
      bcd_q  <= bcd_d;
      init_q <= init_d;
      mode_q <= mode_d;
      rw_q   <= rw_d;
      for (int n = 0; n < 3; n++) begin
        state_q[n] <= state_d[n];
        hold_q[n]  <= hold_d[n];
      end
    end
  end
  assign COUNTER_SELECTOR = sel_q;
  assign NEW_COUNT        = nc_q;
  assign TWO_BYTE_COUNTER = {&rw_q[5:4], &rw_q[3:2], &rw_q[1:0]};
  assign INITIAL_COUNT    = init_q;
  assign MODE             = mode_q;
  assign BCD              = bcd_q;
  assign CNT_RW           = rw_q;
`ifdef COUNTER_LATCH_CMD_EN
  logic [2:0] latch_q;
  always_ff @(posedge CLK) begin
    latch_q <= RESET ? 3'b000 : ({3{WR && ADDR == 2'd3 && DATA_IN[5:4] == 2'd0}} & (3'b001 << DATA_IN[7:6]));
  end
  assign LATCH = latch_q;
`endif
endmodule

// File: tb/tb_counter_load_sequencer.sv
// tb_counter_load_sequencer: directed-vector bench for counter_load_sequencer.
module tb_counter_load_sequencer;
  logic        clk = 1'b0;
  logic        rst, wr;
  logic [1:0]  addr;
  logic [7:0]  din;
  logic [2:0]  sel, nc, two, bcd;
  logic [23:0] init;
  logic [8:0]  mode;
  logic [5:0]  cnt_rw;
  int          total = 0;
  int          bad = 0;
`ifdef COUNTER_LATCH_CMD_EN
  logic [2:0]  latch;
`endif
  counter_load_sequencer #(.LOAD_HOLD(2)) dut (
    .CLK(clk),
    .RESET(rst),
    .WR(wr),
    .ADDR(addr),
    .DATA_IN(din),
    .COUNTER_SELECTOR(sel),
    .NEW_COUNT(nc),
    .TWO_BYTE_COUNTER(two),
    .INITIAL_COUNT(init),
    .MODE(mode),
    .BCD(bcd),
    .CNT_RW(cnt_rw)
`ifdef COUNTER_LATCH_CMD_EN
    ,
    .LATCH(latch)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic write(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1;
    addr = a;
    din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    wr = 1'b0;
    addr = 2'd0;
    din = 8'h00;
    repeat (2) tick();
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_nc", 32'(nc), 32'h7);
    chk("rst_two", 32'(two), 32'h0);
    chk("rst_init", 32'(init), 32'h0);
    chk("rst_mode", 32'(mode), 32'h0);
    chk("rst_bcd_rw", 32'({bcd, cnt_rw}), 32'h0);
    rst = 1'b0;
    write(2'd2, 8'h55);
    chk("unprog_init", 32'(init), 32'h0);
    chk("unprog_nc", 32'(nc), 32'h7);
    chk("unprog_sel", 32'(sel), 32'h0);
    write(2'd3, 8'h10);
    chk("c0_sel_low", 32'(sel), 32'h0);
    chk("c0_nc_low", 32'(nc), 32'h6);
    chk("c0_mode", 32'(mode), 32'h0);
    chk("c0_two", 32'(two), 32'h0);
    chk("c0_rw", 32'(cnt_rw), 32'h01);
    write(2'd0, 8'h03);
    chk("c0_sel_high", 32'(sel), 32'h1);
    chk("c0_init", 32'(init), 32'h000003);
    chk("c0_hold1", 32'(nc), 32'h6);
    tick();
    chk("c0_hold2", 32'(nc), 32'h6);
    tick();
    chk("c0_run", 32'(nc), 32'h7);
    write(2'd0, 8'h0C);
    chk("c0_reload_nc", 32'(nc), 32'h6);
    chk("c0_reload_init", 32'(init), 32'h00000C);
    tick();
    chk("c0_reload_hold", 32'(nc), 32'h6);
    tick();
    chk("c0_reload_run", 32'(nc), 32'h7);
    write(2'd3, 8'h70);
    chk("c1_two", 32'(two), 32'h2);
    chk("c1_sel_low", 32'(sel), 32'h1);
    chk("c1_nc", 32'(nc), 32'h5);
    chk("c1_rw", 32'(cnt_rw), 32'h0D);
    write(2'd1, 8'h00);
    chk("c1_lsb", 32'(init), 32'h00000C);
    chk("c1_sel_high", 32'(sel), 32'h3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("c1_wait_msb", 32'(nc), 32'h5);
    end
    write(2'd1, 8'h01);
    chk("c1_msb", 32'(init), 32'h00010C);
    chk("c1_hold1", 32'(nc), 32'h5);
    tick();
    chk("c1_hold2", 32'(nc), 32'h5);
    tick();
    chk("c1_run", 32'(nc), 32'h7);
    write(2'd3, 8'hB0);
    chk("c2_rw11", 32'(cnt_rw), 32'h3D);
    write(2'd2, 8'hAA);
    chk("c2_lsb", 32'(init), 32'hAA010C);
    chk("c2_wait_msb", 32'(nc), 32'h3);
    write(2'd3, 8'h9A);
    chk("c2_sel_low", 32'(sel), 32'h3);
    chk("c2_mode", 32'(mode[8:6]), 32'h5);
    chk("c2_rw01", 32'(cnt_rw), 32'h1D);
    chk("c2_two", 32'(two), 32'h2);
    tick();
    chk("c2_sel_high", 32'(sel), 32'h7);
    chk("c2_nc_wait", 32'(nc), 32'h3);
    write(2'd2, 8'h77);
    chk("c2_one_byte", 32'(init), 32'h77010C);
    chk("c2_hold1", 32'(nc), 32'h3);
    tick();
    chk("c2_hold2", 32'(nc), 32'h3);
    tick();
    chk("c2_run", 32'(nc), 32'h7);
    write(2'd3, 8'h1D);
    chk("remap_mode", 32'(mode), 32'h142);
    chk("remap_bcd", 32'(bcd), 32'h1);
    chk("remap_sel", 32'(sel), 32'h6);
    chk("remap_nc", 32'(nc), 32'h6);
    write(2'd3, 8'h40);
    chk("latchcmd_mode", 32'(mode), 32'h142);
    chk("latchcmd_rw", 32'(cnt_rw), 32'h1D);
    chk("latchcmd_sel", 32'(sel), 32'h7);
    chk("latchcmd_nc", 32'(nc), 32'h6);
`ifdef COUNTER_LATCH_CMD_EN
    chk("latch_pulse", 32'(latch), 32'h2);
`endif
    tick();
`ifdef COUNTER_LATCH_CMD_EN
    chk("latch_clear", 32'(latch), 32'h0);
`endif
    write(2'd3, 8'hC0);
    chk("readback_ignored", 32'({sel, nc, mode}), 32'({3'h7, 3'h6, 9'h142}));
    write(2'd0, 8'h05);
    chk("c0_hold_init", 32'(init), 32'h770105);
    chk("c0_hold_nc", 32'(nc), 32'h6);
    rst = 1'b1;
    tick();
    chk("midrst_nc", 32'(nc), 32'h7);
    chk("midrst_sel", 32'(sel), 32'h0);
    chk("midrst_init", 32'(init), 32'h0);
    chk("midrst_cfg", 32'({two, mode, bcd, cnt_rw}), 32'h0);
    rst = 1'b0;
    write(2'd1, 8'h33);
    chk("post_rst_unprog", 32'({init, nc}), 32'({24'h0, 3'h7}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
